// File: rtl/pc_unit_if.sv
// Request/response bundle for pc_unit: fetch-side requests in, PC and return-stack status out.
interface pc_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall;
  logic              exception;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] instruction_address;
  logic [ADDR_W-1:0] epc;
  logic              ras_empty;
  logic              ras_overflow;
  logic              ras_underflow;

  modport master (
    output stall, exception, redirect_valid, redirect_addr, call, ret,
    input  instruction_address, epc, ras_empty, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, exception, redirect_valid, redirect_addr, call, ret,
    output instruction_address, epc, ras_empty, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_unit.sv
// MIPS fetch program counter: exception > redirect > stall > call/ret > sequential, all on the
// falling clock edge. Define PC_RAS_EN to build the circular return-address stack.
module pc_unit #(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        STEP       = 1,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0]  EXC_VECTOR = ADDR_W'(32'h0000_0080),
  parameter int unsigned        RAS_DEPTH  = 4
) (
  input  logic       clock,
  input  logic       reset,
  pc_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    ACT_EXC, ACT_REDIR, ACT_STALL, ACT_SWAP, ACT_POP, ACT_UNF, ACT_PUSH, ACT_SEQ
  } action_e;

  action_e           action;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_q + ADDR_W'(STEP);

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d, top_idx, wr_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              empty_q, ovf_q, ovf_d, unf_q, unf_d;
  logic              push_we;

  // sp_q is the next free slot; the newest entry sits one below it.
  assign top_idx = sp_q - PTR_W'(1);
`else
  logic unused_ras;
  assign unused_ras = ^{bus.call, bus.ret};
`endif

  always_comb begin
    action = ACT_SEQ;
    if (bus.exception)           action = ACT_EXC;
    else if (bus.redirect_valid) action = ACT_REDIR;
    else if (bus.stall)          action = ACT_STALL;
`ifdef PC_RAS_EN
    else if (bus.call && bus.ret && !empty_q) action = ACT_SWAP;
    else if (bus.ret && !empty_q)             action = ACT_POP;
    else if (bus.ret && !bus.call)            action = ACT_UNF;
    else if (bus.call)                        action = ACT_PUSH;
`endif
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    pc_d  = pc_q;
    epc_d = epc_q;
`ifdef PC_RAS_EN
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = 1'b0;
    push_we = 1'b0;
    wr_idx  = sp_q;
`endif
    case (action)
      ACT_EXC: begin
        epc_d = pc_q;
        pc_d  = EXC_VECTOR;
      end
      ACT_REDIR: pc_d = bus.redirect_addr;
      ACT_STALL: pc_d = pc_q;
`ifdef PC_RAS_EN
      ACT_SWAP: begin
        pc_d    = stack_q[top_idx];
        push_we = 1'b1;
        wr_idx  = top_idx;
      end
      ACT_POP: begin
        pc_d  = stack_q[top_idx];
        sp_d  = top_idx;
        cnt_d = cnt_q - CNT_W'(1);
      end
      ACT_UNF: begin
        pc_d  = pc_inc;
        unf_d = 1'b1;
      end
      ACT_PUSH: begin
        pc_d    = pc_inc;
        push_we = 1'b1;
        sp_d    = sp_q + PTR_W'(1);
        // When full, sp_q already points at the oldest entry, so the write evicts it.
        if (cnt_q == CNT_W'(RAS_DEPTH)) ovf_d = 1'b1;
        else                            cnt_d = cnt_q + CNT_W'(1);
      end
`endif
      default: pc_d = pc_inc;
    endcase
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_ADDR;
      epc_q <= '0;
`ifdef PC_RAS_EN
      sp_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      pc_q  <= pc_d;
      epc_q <= epc_d;
`ifdef PC_RAS_EN
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`endif
    end
  end

`ifdef PC_RAS_EN
  // NOTE: stack storage has no reset; the count guards every read so stale entries never leak.
  always_ff @(negedge clock) begin
    if (push_we) stack_q[wr_idx] <= pc_inc;
  end

  assign bus.ras_empty     = empty_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
`else
  assign bus.ras_empty     = 1'b1;
  assign bus.ras_overflow  = 1'b0;
  assign bus.ras_underflow = 1'b0;
`endif

  assign bus.instruction_address = pc_q;
  assign bus.epc                 = epc_q;

endmodule
